// File: rtl/avr_serial_pkg.sv
// Shared definitions for the FPGA-to-AVR serial link.
// Holds the UART FSM state encoding and the default bit period.
package avr_serial_pkg;

  // UART frame sequencer states (shared with the receive side).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_t;

  // 50 MHz system clock / 500 kbaud link.
  localparam int CLK_PER_BIT_DEF = 100;

endpackage

// File: rtl/avr_tx_fifo.sv
// Synchronous byte FIFO feeding the AVR transmitter.
// Ports: clk, rst (sync, active high), wr/wdata push, rd pop,
// rdata (head, combinational), level, full, empty.
module avr_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A write while full is dropped even if a pop frees a slot
  // on the same edge.
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (do_rd) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/avr_serial_tx.sv
// Buffered 8N1 UART transmitter toward the AVR, gated by its busy flag.
// Ports: clk, rst (sync, active high), data/new_data write, ready,
// overflow, level, block (async AVR busy), tx (idle high).
module avr_serial_tx
  import avr_serial_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data,
  input  logic                         new_data,
  output logic                         ready,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  input  logic                         block,
  output logic                         tx
);

  localparam int CW = $clog2(CLK_PER_BIT);

  serial_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          block_m;
  logic          block_s;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          last;
  logic          can_start;
  logic          pop;

  avr_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (new_data),
    .wdata (data),
    .rd    (pop),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign ready    = ~full;
  assign overflow = new_data & full;

  // block is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_m <= 1'b0;
      block_s <= 1'b0;
    end else begin
      block_m <= block;
      block_s <= block_m;
    end
  end

  assign last      = (cnt == CW'(CLK_PER_BIT - 1));
  assign can_start = ~empty & ~block_s;

  // Busy flag only gates frame starts; frames in flight always finish.
  assign pop = can_start &
               ((state == IDLE) | ((state == STOP) & last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (can_start) begin
            state <= START;
            shreg <= head;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (last) begin
            state <= DATA;
            cnt   <= '0;
            bitn  <= '0;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            if (bitn == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitn  <= bitn + 3'd1;
              shreg <= {1'b0, shreg[7:1]};
              tx    <= shreg[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (last) begin
            cnt <= '0;
            if (can_start) begin
              state <= START;
              shreg <= head;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Scoreboard bench for avr_serial_tx: driver queues expected bytes,
// a tx-line monitor decodes frames and compares them in order.
module tb_avr_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          new_data = 1'b0;
  logic          block = 1'b0;
  logic          ready;
  logic          overflow;
  logic [LW-1:0] level;
  logic          tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_started = 0;
  logic [7:0] sb[$];
  int starts[$];

  avr_serial_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .new_data (new_data),
    .ready    (ready),
    .overflow (overflow),
    .level    (level),
    .block    (block),
    .tx       (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget,
                             input string name);
    int t;
    t = 0;
    while (frames_started < n && t < budget) begin
      step;
      t++;
    end
    check(name, frames_started, n);
  endtask

  task automatic drain(input int budget, input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      step;
      t++;
    end
    check(name, sb.size(), 0);
    sb.delete();
    repeat (4) step;
  endtask

  // Monitor: 10 bits of CPB samples each, every bit steady, stop high.
  initial begin : monitor
    logic       s [FRAME];
    logic [7:0] got;
    int         bad;
    bit         abort;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        starts.push_back(cyc);
        frames_started++;
        s[0] = tx;
        abort = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          s[i] = tx;
        end
        if (!abort) begin
          bad = 0;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
              if (s[k*CPB+j] !== s[k*CPB]) bad++;
          for (int k = 0; k < 8; k++) got[k] = s[(k+1)*CPB];
          check("bit_steady", bad, 0);
          check("stop_bit", s[9*CPB], 1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %02h expected none", got);
          end else begin
            check("frame_byte", got, sb.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int bad;
    int f0;
    int cs;
    int td;
    int ovf;
    int g;
    int n;

    // Reset and idle
    repeat (3) step;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step;
      if (tx !== 1'b1 || ready !== 1'b1 || level !== '0) bad++;
    end
    check("idle_stable", bad, 0);

    // Single byte 0xA5
    step;
    data = 8'hA5;
    new_data = 1'b1;
    sb.push_back(8'hA5);
    step;
    new_data = 1'b0;
    check("single_level1", level, 1);
    check("single_tx_before_pop", tx, 1);
    step;
    check("single_tx_start", tx, 0);
    check("single_level0", level, 0);
    check("single_started", frames_started, 1);
    repeat (CPB) step;
    check("single_bit0", tx, 1);
    repeat (CPB) step;
    check("single_bit1", tx, 0);
    repeat (FRAME - 1 - 2 * CPB) step;
    check("single_stop", tx, 1);
    step;
    check("single_after", tx, 1);
    check("single_count", frames_started, 1);
    drain(200, "single_drain");

    // Back-to-back, queued behind block
    block = 1'b1;
    repeat (3) step;
    f0 = frames_started;
    data = 8'h00;
    new_data = 1'b1;
    sb.push_back(8'h00);
    step;
    check("b2b_level1", level, 1);
    data = 8'hFF;
    sb.push_back(8'hFF);
    step;
    check("b2b_level2", level, 2);
    data = 8'h3C;
    sb.push_back(8'h3C);
    step;
    new_data = 1'b0;
    check("b2b_level3", level, 3);
    block = 1'b0;
    wait_starts(f0 + 1, 20, "b2b_start1");
    check("b2b_level_a", level, 2);
    wait_starts(f0 + 2, FRAME + 5, "b2b_start2");
    check("b2b_gap1", starts[f0+1] - starts[f0], FRAME);
    check("b2b_level_b", level, 1);
    wait_starts(f0 + 3, FRAME + 5, "b2b_start3");
    check("b2b_gap2", starts[f0+2] - starts[f0+1], FRAME);
    check("b2b_level_c", level, 0);
    drain(FRAME * 2, "b2b_drain");

    // Flow control mid-frame
    f0 = frames_started;
    step;
    data = 8'h5A;
    new_data = 1'b1;
    sb.push_back(8'h5A);
    step;
    data = 8'hC3;
    sb.push_back(8'hC3);
    step;
    new_data = 1'b0;
    wait_starts(f0 + 1, 20, "flow_start1");
    cs = starts[f0];
    repeat (15) step;
    block = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      step;
      if (cyc - cs >= FRAME && tx !== 1'b1) bad++;
    end
    check("flow_held_high", bad, 0);
    check("flow_one_frame", frames_started, f0 + 1);
    check("flow_frame1_done", sb.size(), 1);
    block = 1'b0;
    td = cyc;
    wait_starts(f0 + 2, 20, "flow_start2");
    check("flow_release_lat",
          (starts[f0+1] - td >= 2) && (starts[f0+1] - td <= 3), 1);
    drain(FRAME * 2, "flow_drain");

    // Full and overflow
    block = 1'b1;
    repeat (3) step;
    f0 = frames_started;
    ovf = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      step;
      data = 8'($urandom);
      new_data = 1'b1;
      if (i < DEPTH) sb.push_back(data);
      #1;
      if (overflow === 1'b1) ovf++;
      if (i == DEPTH) begin
        check("full_ready", ready, 0);
        check("full_level", level, DEPTH);
      end
    end
    step;
    new_data = 1'b0;
    #1;
    check("full_ovf_clear", overflow, 0);
    check("full_ovf_count", ovf, 1);
    check("full_level_kept", level, DEPTH);
    block = 1'b0;
    wait_starts(f0 + 1, 20, "full_start");
    check("full_ready_back", ready, 1);
    check("full_level_pop", level, DEPTH - 1);
    drain(FRAME * (DEPTH + 2), "full_drain");
    check("full_frames", frames_started - f0, DEPTH);

    // Reset mid-frame
    f0 = frames_started;
    for (int i = 0; i < 5; i++) begin
      step;
      data = 8'($urandom);
      new_data = 1'b1;
      sb.push_back(data);
    end
    step;
    new_data = 1'b0;
    wait_starts(f0 + 1, 20, "rst_start");
    repeat (4 * CPB + 1) step;
    rst = 1'b1;
    step;
    check("rst_tx", tx, 1);
    check("rst_level", level, 0);
    check("rst_ready", ready, 1);
    sb.delete();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step;
      if (tx !== 1'b1) bad++;
    end
    check("rst_quiet", bad, 0);
    check("rst_no_frames", frames_started, f0 + 1);

    // Randomized bursts with busy toggling
    for (int b = 0; b < 20; b++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        step;
        data = 8'($urandom);
        new_data = 1'b1;
        sb.push_back(data);
        if ($urandom_range(0, 3) == 0) block = ~block;
        g = $urandom_range(0, 3);
        if (g != 0) begin
          step;
          new_data = 1'b0;
          repeat (g - 1) step;
        end
      end
      step;
      new_data = 1'b0;
      repeat ($urandom_range(0, 30)) step;
      block = 1'b0;
      drain(FRAME * 16, "rand_drain");
    end

    repeat (5) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
